pulse_mode_transmitter: RTL and testbench

Generates the pulse-width-coded mode signal that the mode-detecting receiver decodes. On a start request it emits a burst of fixed-period pulses on `AUX_OUTPUT`, each either short (mode 0) or long (mode 1). The receiver samples the line a fixed delay after each rising edge and needs several consecutive matching pulses, so the burst length is configurable. The block sits on the board's 50 MHz domain and drives the auxiliary line toward the relay controller.

---
 rtl/pulse_mode_transmitter_if.sv | 23 ++
 rtl/pulse_mode_transmitter.sv | 109 ++++++++++
 tb/tb_pulse_mode_transmitter.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pulse_mode_transmitter_if.sv
// Handshake and status bundle between a burst requester and pulse_mode_transmitter.
// ABORT exists only when PULSE_TX_ABORT_EN is defined.
interface pulse_mode_transmitter_if;
    logic       START;
    logic       MODE_SEL;
    logic       AUX_OUTPUT;
    logic       BUSY;
    logic       DONE;
    logic [3:0] PULSE_COUNT;
`ifdef PULSE_TX_ABORT_EN
    logic       ABORT;

    modport master (output START, MODE_SEL, ABORT,
                    input  AUX_OUTPUT, BUSY, DONE, PULSE_COUNT);
    modport slave  (input  START, MODE_SEL, ABORT,
                    output AUX_OUTPUT, BUSY, DONE, PULSE_COUNT);
`else
    modport master (output START, MODE_SEL,
                    input  AUX_OUTPUT, BUSY, DONE, PULSE_COUNT);
    modport slave  (input  START, MODE_SEL,
                    output AUX_OUTPUT, BUSY, DONE, PULSE_COUNT);
`endif
endinterface

// File: rtl/pulse_mode_transmitter.sv
// Emits a burst of REPEAT fixed-period pulses, short (mode 0) or long (mode 1), on AUX_OUTPUT.
// Optional macro PULSE_TX_ABORT_EN adds an ABORT input that ends a burst early without DONE.
//
//   state | meaning
//   IDLE  | waiting for START, outputs low, PULSE_COUNT holds last value
//   HIGH  | pulse high phase, counter running from 0 up to width-1
//   LOW   | low phase, counter running on up to PERIOD-1
module pulse_mode_transmitter #(
    parameter int SHORT_WIDTH = 50500,
    parameter int LONG_WIDTH  = 95000,
    parameter int PERIOD      = 1050000,
    parameter int REPEAT      = 8,
    parameter int CNT_W       = 21
) (
    input  logic                     CLOCK_50,
    input  logic                     Clear,
    pulse_mode_transmitter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(SHORT_WIDTH - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_WIDTH - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [3:0]       REPEAT_N    = 4'(REPEAT);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             mode_q, mode_nx;
    logic [3:0]       count_q, count_nx;
    logic             done_nx;
    logic             aux_q, busy_q, done_q;
    logic [CNT_W-1:0] width_last;

    always_ff @(posedge CLOCK_50 or posedge Clear) begin
        if (Clear) begin
            state   <= IDLE;
            cnt     <= '0;
            mode_q  <= 1'b0;
            count_q <= 4'd0;
            aux_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            mode_q  <= mode_nx;
            count_q <= count_nx;
            aux_q   <= (state_nx == HIGH);
            busy_q  <= (state_nx != IDLE);
            done_q  <= done_nx;
        end
    end

    // The counter spans the whole period; it only clears when a new period starts.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        mode_nx    = mode_q;
        count_nx   = count_q;
        done_nx    = 1'b0;
        width_last = mode_q ? LONG_LAST : SHORT_LAST;
        case (state)
            IDLE: begin
                if (bus.START) begin
                    mode_nx  = bus.MODE_SEL;
                    cnt_nx   = '0;
                    count_nx = 4'd1;
                    state_nx = HIGH;
                end
            end
            HIGH: begin
                cnt_nx = cnt + CNT_ONE;
                if (cnt == width_last) state_nx = LOW;
            end
            LOW: begin
                if (cnt == PERIOD_LAST) begin
                    cnt_nx = '0;
                    if (count_q < REPEAT_N) begin
                        count_nx = count_q + 4'd1;
                        state_nx = HIGH;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
`ifdef PULSE_TX_ABORT_EN
        if (bus.ABORT && (state != IDLE)) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            mode_nx  = mode_q;
            count_nx = count_q;
            done_nx  = 1'b0;
        end
`endif
    end

    assign bus.AUX_OUTPUT  = aux_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.PULSE_COUNT = count_q;

endmodule

// File: tb/tb_pulse_mode_transmitter.sv
// Directed bench for pulse_mode_transmitter with small widths (5/9/20, REPEAT 3 and REPEAT 1).
// ABORT steps run only when PULSE_TX_ABORT_EN is defined.
module tb_pulse_mode_transmitter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   s;
    logic seen;

    pulse_mode_transmitter_if bus0();
    pulse_mode_transmitter_if bus1();

    pulse_mode_transmitter #(.SHORT_WIDTH(5), .LONG_WIDTH(9), .PERIOD(20), .REPEAT(3), .CNT_W(5))
        u_dut (.CLOCK_50(clk), .Clear(rst), .bus(bus0));

    pulse_mode_transmitter #(.SHORT_WIDTH(5), .LONG_WIDTH(9), .PERIOD(20), .REPEAT(1), .CNT_W(5))
        u_one (.CLOCK_50(clk), .Clear(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Walks one REPEAT=3 burst whose first high cycle is b, through its DONE cycle b+60.
    task automatic check_burst(input int b, input int w);
        int rel;
        for (int c = b; c <= b + 60; c++) begin
            tick();
            rel = c - b;
            if (rel < 60) begin
                chk("aux",   32'(bus0.AUX_OUTPUT),  32'(((rel % 20) < w) ? 1 : 0));
                chk("busy",  32'(bus0.BUSY),        32'd1);
                chk("done",  32'(bus0.DONE),        32'd0);
                chk("count", 32'(bus0.PULSE_COUNT), 32'(1 + rel / 20));
            end else begin
                chk("aux_end",   32'(bus0.AUX_OUTPUT),  32'd0);
                chk("busy_end",  32'(bus0.BUSY),        32'd0);
                chk("done_end",  32'(bus0.DONE),        32'd1);
                chk("count_end", 32'(bus0.PULSE_COUNT), 32'd3);
            end
            bus0.START    = (rel == 19 || rel == 39);
            bus0.MODE_SEL = ~bus0.MODE_SEL;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        rst    = 1'b1;
        bus0.START = 1'b0;  bus0.MODE_SEL = 1'b0;
        bus1.START = 1'b0;  bus1.MODE_SEL = 1'b0;
`ifdef PULSE_TX_ABORT_EN
        bus0.ABORT = 1'b0;
        bus1.ABORT = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aux",   32'(bus0.AUX_OUTPUT),  32'd0);
        chk("rst_busy",  32'(bus0.BUSY),        32'd0);
        chk("rst_done",  32'(bus0.DONE),        32'd0);
        chk("rst_count", 32'(bus0.PULSE_COUNT), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Mode 0 burst requested in cycle 10: highs 11-15, 31-35, 51-55, DONE 71.
        repeat (10) tick();
        bus0.START = 1'b1;
        bus0.MODE_SEL = 1'b0;
        check_burst(11, 5);

        // START during the DONE cycle: mode 1 burst rises the very next cycle.
        bus0.START = 1'b1;
        bus0.MODE_SEL = 1'b1;
        check_burst(72, 9);

        repeat (3) tick();
        chk("idle_count", 32'(bus0.PULSE_COUNT), 32'd3);
        chk("idle_busy",  32'(bus0.BUSY),        32'd0);
        chk("idle_aux",   32'(bus0.AUX_OUTPUT),  32'd0);

        // Asynchronous Clear three cycles into a burst.
        bus0.START = 1'b1;
        bus0.MODE_SEL = 1'b0;
        tick();
        bus0.START = 1'b0;
        chk("pre_clr_aux", 32'(bus0.AUX_OUTPUT), 32'd1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("clr_aux",   32'(bus0.AUX_OUTPUT),  32'd0);
        chk("clr_busy",  32'(bus0.BUSY),        32'd0);
        chk("clr_count", 32'(bus0.PULSE_COUNT), 32'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus0.DONE || bus0.AUX_OUTPUT || bus0.BUSY) seen = 1'b1;
        end
        chk("clr_quiet", 32'(seen), 32'd0);

        // REPEAT=1 instance: one pulse, DONE 21 cycles after the request.
        bus1.START = 1'b1;
        bus1.MODE_SEL = 1'b0;
        s = cyc;
        tick();
        bus1.START = 1'b0;
        chk("one_aux_rise", 32'(bus1.AUX_OUTPUT),  32'd1);
        chk("one_count",    32'(bus1.PULSE_COUNT), 32'd1);
        repeat (5) tick();
        chk("one_aux_fall", 32'(bus1.AUX_OUTPUT), 32'd0);
        chk("one_busy_mid", 32'(bus1.BUSY),       32'd1);
        repeat (14) tick();
        chk("one_busy_last", 32'(bus1.BUSY), 32'd1);
        chk("one_done_early", 32'(bus1.DONE), 32'd0);
        tick();
        chk("one_done",  32'(bus1.DONE), 32'd1);
        chk("one_busy",  32'(bus1.BUSY), 32'd0);
        chk("one_delay", 32'(cyc - s),   32'd21);
        tick();
        chk("one_done_clear", 32'(bus1.DONE), 32'd0);

`ifdef PULSE_TX_ABORT_EN
        // ABORT with START 23 cycles after the request: IDLE next cycle, count 2, no DONE.
        bus0.START = 1'b1;
        bus0.MODE_SEL = 1'b0;
        tick();
        bus0.START = 1'b0;
        repeat (22) tick();
        chk("pre_abort_aux", 32'(bus0.AUX_OUTPUT), 32'd1);
        bus0.ABORT = 1'b1;
        bus0.START = 1'b1;
        tick();
        bus0.ABORT = 1'b0;
        bus0.START = 1'b0;
        chk("abort_aux",   32'(bus0.AUX_OUTPUT),  32'd0);
        chk("abort_busy",  32'(bus0.BUSY),        32'd0);
        chk("abort_done",  32'(bus0.DONE),        32'd0);
        chk("abort_count", 32'(bus0.PULSE_COUNT), 32'd2);
        tick();
        chk("abort_done2", 32'(bus0.DONE), 32'd0);
        chk("abort_idle",  32'(bus0.BUSY), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
